// File: rtl/ped_req_arbiter.sv
// ped_req_arbiter
//   Front end between the raw pedestrian push-buttons and the traffic light
//   controller. Each button is synchronised, debounced and turned into one
//   latched request per press. Pending requests age towards an urgent flag.
//   NS and EW requests are arbitrated and presented one at a time over a
//   serve_req/serve_ack handshake.
//
//   Optional feature macro: PED_ARB_STATS_EN adds the served_cnt_ns and
//   served_cnt_ew counters and ports.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   btn_ns, btn_ew      raw buttons (asynchronous, may bounce)
//   serve_ack           controller accepts the current request (pulse)
//   serve_req/_dir      request valid (held until ack) and direction (0=NS, 1=EW)
//   pending_ns/_ew      latched, not yet served requests (button lamps)
//   urgent_ns/_ew       request has waited MAX_WAIT cycles
//   served_cnt_ns/_ew   accepted acks per direction (PED_ARB_STATS_EN only)

// One button: synchroniser, debounce, request latch and wait counter.
module ped_req_lane #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_WAIT        = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic clr_i,   // accepted ack for this direction
  output logic pend_o,
  output logic urg_o
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [1:0]    sync_q;
  logic          db_q, db_d, db_prev_q;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d, rise;
  logic [WW-1:0] wait_q, wait_d;
  logic          urg_q;

  // The counter only advances while the synchronised level disagrees with
  // the debounced level; any agreement restarts the stability window.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_d  = ~db_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  // A rise in the same cycle as the ack keeps the request latched.
  assign rise   = db_q & ~db_prev_q;
  assign pend_d = rise | (pend_q & ~clr_i);

  always_comb begin
    wait_d = wait_q;
    if (pend_q && !pend_d)
      wait_d = '0;
    else if (pend_q && wait_q != WW'(MAX_WAIT))
      wait_d = wait_q + WW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      wait_q    <= '0;
      urg_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_i};
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      wait_q    <= wait_d;
      urg_q     <= (wait_d == WW'(MAX_WAIT));
    end
  end

  assign pend_o = pend_q;
  assign urg_o  = urg_q;
endmodule

module ped_req_arbiter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_WAIT        = 64,
  parameter int HOLDOFF_CYCLES  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_ns,
  input  logic        btn_ew,
  input  logic        serve_ack,
  output logic        serve_req,
  output logic        serve_dir,
  output logic        pending_ns,
  output logic        pending_ew,
  output logic        urgent_ns,
`ifdef PED_ARB_STATS_EN
  output logic        urgent_ew,
  output logic [15:0] served_cnt_ns,
  output logic [15:0] served_cnt_ew
`else
  output logic        urgent_ew
`endif
);
  localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic          dir_q, dir_d;
  logic          last_q, last_d;   // last served direction, 1 = EW
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    btn, pend, urg, clr;
  logic          ack_acc, sel;

  assign btn = {btn_ew, btn_ns};

  genvar g;
  for (g = 0; g < 2; g++) begin : g_lane
    ped_req_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .MAX_WAIT       (MAX_WAIT)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .btn_i (btn[g]),
      .clr_i (clr[g]),
      .pend_o(pend[g]),
      .urg_o (urg[g])
    );
  end

  // Acks are only meaningful while a request is outstanding.
  assign ack_acc = serve_ack & req_q;
  assign clr[0]  = ack_acc & ~dir_q;
  assign clr[1]  = ack_acc &  dir_q;

  // Single pending wins; otherwise urgency, then round-robin on last_q.
  always_comb begin
    if (pend[0] != pend[1])     sel = pend[1];
    else if (urg[0] != urg[1])  sel = urg[1];
    else                        sel = ~last_q;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    dir_d   = dir_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (pend != 2'b00) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          dir_d   = sel;
        end
      end
      S_REQ: begin
        if (serve_ack) begin
          req_d   = 1'b0;
          last_d  = dir_q;
          hold_d  = '0;
          state_d = (HOLDOFF_CYCLES > 0) ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        if (hold_q == HW'(HOLDOFF_CYCLES - 1)) state_d = S_IDLE;
        else                                   hold_d  = hold_q + HW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      dir_q   <= 1'b0;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign serve_req  = req_q;
  assign serve_dir  = dir_q;
  assign pending_ns = pend[0];
  assign pending_ew = pend[1];
  assign urgent_ns  = urg[0];
  assign urgent_ew  = urg[1];

`ifdef PED_ARB_STATS_EN
  logic [15:0] cnt_ns_q, cnt_ew_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_ns_q <= '0;
      cnt_ew_q <= '0;
    end else begin
      if (clr[0] && cnt_ns_q != 16'hFFFF) cnt_ns_q <= cnt_ns_q + 16'd1;
      if (clr[1] && cnt_ew_q != 16'hFFFF) cnt_ew_q <= cnt_ew_q + 16'd1;
    end
  end

  assign served_cnt_ns = cnt_ns_q;
  assign served_cnt_ew = cnt_ew_q;
`endif
endmodule

// File: tb/tb_ped_req_arbiter.sv
module tb_ped_req_arbiter;
  localparam int DEB  = 4;
  localparam int MAXW = 64;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst, btn_ns, btn_ew, serve_ack;
  logic serve_req, serve_dir, pending_ns, pending_ew, urgent_ns, urgent_ew;
`ifdef PED_ARB_STATS_EN
  logic [15:0] served_cnt_ns, served_cnt_ew;
`endif

  always #5 clk = ~clk;

  ped_req_arbiter dut (
    .clk(clk), .rst(rst), .btn_ns(btn_ns), .btn_ew(btn_ew), .serve_ack(serve_ack),
    .serve_req(serve_req), .serve_dir(serve_dir),
    .pending_ns(pending_ns), .pending_ew(pending_ew),
    .urgent_ns(urgent_ns),
`ifdef PED_ARB_STATS_EN
    .urgent_ew(urgent_ew),
    .served_cnt_ns(served_cnt_ns), .served_cnt_ew(served_cnt_ew)
`else
    .urgent_ew(urgent_ew)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int dir; int cyc; } exp_t;
  exp_t exp_q[$];
  int   dir_log[$];

  bit m_s1[2], m_s2[2], m_db[2], m_dbp[2], m_pend[2], m_urg[2];
  int m_run[2], m_age[2], m_served[2];
  bit m_req, m_dir, m_last;
  int free_at, cyc;

  task automatic model_reset();
    for (int x = 0; x < 2; x++) begin
      m_s1[x] = 0; m_s2[x] = 0; m_db[x] = 0; m_dbp[x] = 0;
      m_pend[x] = 0; m_urg[x] = 0; m_run[x] = 0; m_age[x] = 0; m_served[x] = 0;
    end
    m_req = 0; m_dir = 0; m_last = 1; free_at = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit ack_acc, newp, pick;
    bit rise[2];
    bit btn[2];
    int ackdir;
    cyc++;
    btn[0] = btn_ns; btn[1] = btn_ew;
    ack_acc = serve_ack && m_req;
    ackdir  = m_dir;
    for (int x = 0; x < 2; x++) rise[x] = m_db[x] && !m_dbp[x];
    if (ack_acc) begin
      m_req = 0; m_last = m_dir; free_at = cyc + HOLD + 1;
      if (m_served[m_dir] < 65535) m_served[m_dir]++;
    end else if (!m_req && cyc >= free_at && (m_pend[0] || m_pend[1])) begin
      if (m_pend[0] != m_pend[1])     pick = m_pend[1];
      else if (m_urg[0] != m_urg[1])  pick = m_urg[1];
      else                            pick = !m_last;
      m_req = 1; m_dir = pick;
      exp_q.push_back('{dir: int'(pick), cyc: cyc});
    end
    for (int x = 0; x < 2; x++) begin
      newp = rise[x] || (m_pend[x] && !(ack_acc && ackdir == x));
      if (m_pend[x] && !newp)              m_age[x] = 0;
      else if (m_pend[x] && m_age[x] < MAXW) m_age[x]++;
      m_urg[x]  = (m_age[x] == MAXW);
      m_pend[x] = newp;
      // debounced level follows after DEB consecutive disagreeing samples
      m_dbp[x] = m_db[x];
      if (m_s2[x] != m_db[x]) m_run[x]++; else m_run[x] = 0;
      if (m_run[x] == DEB) begin m_db[x] = !m_db[x]; m_run[x] = 0; end
      m_s2[x] = m_s1[x];
      m_s1[x] = btn[x];
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- monitor / scoreboard ----------------
  bit prev_req = 0;
  always @(negedge clk) begin
    exp_t e;
    if (serve_req && !prev_req) begin
      dir_log.push_back(int'(serve_dir));
      if (exp_q.size() == 0) chk("sb_unexpected_req", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sb_dir", int'(serve_dir), e.dir);
        chk("sb_cyc", cyc, e.cyc);
      end
    end
    prev_req = serve_req;
    chk("cyc_serve_req",  int'(serve_req),  int'(m_req));
    chk("cyc_serve_dir",  int'(serve_dir),  int'(m_dir));
    chk("cyc_pending_ns", int'(pending_ns), int'(m_pend[0]));
    chk("cyc_pending_ew", int'(pending_ew), int'(m_pend[1]));
    chk("cyc_urgent_ns",  int'(urgent_ns),  int'(m_urg[0]));
    chk("cyc_urgent_ew",  int'(urgent_ew),  int'(m_urg[1]));
  end

  // ---------------- ack responder ----------------
  int ack_dly = 2;   // <0 withholds the ack
  bit spur_en = 0;   // random acks while no request is outstanding
  int ack_wait = 0;
  always @(negedge clk) begin
    if (rst) begin
      serve_ack = 0; ack_wait = 0;
    end else if (serve_ack) begin
      serve_ack = 0; ack_wait = 0;
    end else if (serve_req) begin
      if (ack_dly >= 0) begin
        if (ack_wait >= ack_dly) begin serve_ack = 1; ack_wait = 0; end
        else ack_wait++;
      end
    end else begin
      ack_wait = 0;
      if (spur_en && $urandom_range(0, 7) == 0) serve_ack = 1;
    end
  end

  function automatic int log_at(input int i);
    return (i < dir_log.size()) ? dir_log[i] : -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n0, r;
    serve_ack = 0;
    btn_ns = 0; btn_ew = 0; rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_serve_req", int'(serve_req), 0);
    chk("rst_pending_ns", int'(pending_ns), 0);
    chk("rst_urgent_ew", int'(urgent_ew), 0);
    rst = 0;
    repeat (3) @(negedge clk);

    // bounce then stable high: one request, 6 cycles after the stable start
    n0 = dir_log.size();
    for (int i = 0; i < 8; i++) begin
      btn_ns = (i % 2 == 0);
      @(negedge clk);
    end
    btn_ns = 1;
    repeat (6) @(negedge clk);
    chk("bounce_lat_early", int'(pending_ns), 0);
    @(negedge clk);
    chk("bounce_lat", int'(pending_ns), 1);
    repeat (3) @(negedge clk);
    btn_ns = 0;
    repeat (30) @(negedge clk);
    chk("bounce_one_req", dir_log.size() - n0, 1);
    chk("bounce_dir", log_at(n0), 0);

    // long hold: exactly one request until release and re-press
    ack_dly = 5;
    n0 = dir_log.size();
    btn_ew = 1;
    repeat (300) @(negedge clk);
    chk("hold_one_req", dir_log.size() - n0, 1);
    chk("hold_pend_clr", int'(pending_ew), 0);
    btn_ew = 0;
    repeat (10) @(negedge clk);
    chk("release_no_req", dir_log.size() - n0, 1);
    btn_ew = 1;
    repeat (8) @(negedge clk);
    btn_ew = 0;
    repeat (30) @(negedge clk);
    chk("repress_req", dir_log.size() - n0, 2);

    // simultaneous presses, twice: NS then EW each time
    ack_dly = 0;
    n0 = dir_log.size();
    for (int rep = 0; rep < 2; rep++) begin
      btn_ns = 1; btn_ew = 1;
      repeat (10) @(negedge clk);
      btn_ns = 0; btn_ew = 0;
      repeat (40) @(negedge clk);
    end
    chk("pair_count", dir_log.size() - n0, 4);
    chk("pair_dir0", log_at(n0),     0);
    chk("pair_dir1", log_at(n0 + 1), 1);
    chk("pair_dir2", log_at(n0 + 2), 0);
    chk("pair_dir3", log_at(n0 + 3), 1);

    // urgency while NS request outstanding does not alter it
    ack_dly = -1;
    n0 = dir_log.size();
    btn_ns = 1;
    repeat (8) @(negedge clk);
    btn_ns = 0; btn_ew = 1;
    repeat (8) @(negedge clk);
    btn_ew = 0;
    repeat (70) @(negedge clk);
    chk("urg_ew_set", int'(urgent_ew), 1);
    chk("urg_dir_kept", int'(serve_dir), 0);
    chk("urg_req_held", int'(serve_req), 1);
    ack_dly = 0;
    repeat (20) @(negedge clk);
    chk("urg_count", dir_log.size() - n0, 2);
    chk("urg_second_dir", log_at(n0 + 1), 1);
    chk("urg_ew_clr", int'(urgent_ew), 0);
    chk("urg_pend_clr", int'(pending_ew), 0);

    // async reset mid-request with both pending
    ack_dly = -1;
    btn_ns = 1; btn_ew = 1;
    repeat (8) @(negedge clk);
    btn_ns = 0; btn_ew = 0;
    chk("pre_rst_req", int'(serve_req), 1);
    chk("pre_rst_pend", int'({pending_ew, pending_ns}), 3);
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_req", int'(serve_req), 0);
    chk("async_rst_pend", int'({pending_ew, pending_ns}), 0);
    chk("async_rst_dir", int'(serve_dir), 0);
    @(negedge clk);
    rst = 0;
    ack_dly = 0;
    n0 = dir_log.size();
    repeat (40) @(negedge clk);
    chk("post_rst_no_req", dir_log.size() - n0, 0);

    // randomized traffic with spurious acks
    spur_en = 1;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) btn_ns = ~btn_ns;
      if ($urandom_range(0, 11) == 0) btn_ew = ~btn_ew;
      if (i % 40 == 0) begin
        r = $urandom_range(0, 7);
        ack_dly = (r == 7) ? 80 : r;
      end
    end
    btn_ns = 0; btn_ew = 0; ack_dly = 0; spur_en = 0;
    repeat (100) @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);
`ifdef PED_ARB_STATS_EN
    chk("stats_ns", int'(served_cnt_ns), m_served[0]);
    chk("stats_ew", int'(served_cnt_ew), m_served[1]);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ped_req_arbiter.md
Name: ped_req_arbiter

Overview:
- Front end between the raw pedestrian push-buttons and the traffic light controller's pedestrian inputs.
- Synchronises and debounces both buttons, and latches one request per press.
- Ages pending requests and arbitrates NS vs EW service.
- Presents one request at a time to the controller over a req/ack handshake, so bounce, long holds and simultaneous presses reach the controller as clean, single, fairly ordered requests.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles (post-synchroniser) before a button level change is accepted; legal range 1..255.
- MAX_WAIT, 64: cycles a request may stay pending before it is flagged urgent; legal range ≥ 1.
- HOLDOFF_CYCLES, 8: idle cycles after each ack before the next request may be issued; 0 means none.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- btn_ns  in  1  raw NS pedestrian button (asynchronous, may bounce)
- btn_ew  in  1  raw EW pedestrian button (asynchronous, may bounce)
- serve_ack  in  1  controller accepts the current request (single-cycle pulse)
- serve_req  out  1  request valid, held until ack
- serve_dir  out  1  direction of request: 0 = NS, 1 = EW
- pending_ns  out  1  NS request latched, not yet served (button lamp)
- pending_ew  out  1  EW request latched, not yet served
- urgent_ns  out  1  NS wait counter reached MAX_WAIT
- urgent_ew  out  1  EW wait counter reached MAX_WAIT

Behaviour:
- Reset (async, rst=1): all outputs 0; synchronisers, debounce counters, wait counters and pending latches cleared; FSM goes to IDLE; last_served = EW, so NS wins the first tie. Requests pending at reset are discarded.
- Synchroniser: 2 flops per button; raw inputs are never used elsewhere.
- Debounce: per-button counter, width $clog2(DEBOUNCE_CYCLES+1). It counts while the synchronised level differs from the debounced level and clears on any match. When it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Latency: button held high from edge E sets pending_x at edge E+2+DEBOUNCE_CYCLES (E+6 at default).
- Request latch:
  - pending_x sets on the debounced rising edge only. A held button gives exactly one request; no re-arm until a debounced release.
  - pending_x clears on the cycle where serve_ack=1, serve_req=1 and serve_dir matches x.
  - A new debounced rise in that same cycle wins: pending stays 1.
  - A rise while already pending is absorbed; there is no queueing depth.
- Wait counters:
  - Per direction, width $clog2(MAX_WAIT+1).
  - Increments each cycle pending_x=1 and saturates at MAX_WAIT.
  - Clears when pending_x clears.
  - urgent_x = (counter == MAX_WAIT), registered with the counter.
- FSM states IDLE, REQ, HOLDOFF:
  - IDLE, no pending: stay in IDLE.
  - IDLE, exactly one pending: select it.
  - IDLE, both pending: an urgent direction beats a non-urgent one. If both or neither are urgent, select the direction != last_served (round-robin).
  - On selection, next cycle: serve_req=1, serve_dir = selection, state = REQ.
  - REQ: serve_req and serve_dir stay constant until ack; a change in urgency does not alter an outstanding request.
  - REQ, on serve_ack: clear that pending; last_served = serve_dir; serve_req=0 from the next cycle. Go to HOLDOFF if HOLDOFF_CYCLES>0, else IDLE.
  - HOLDOFF: counts HOLDOFF_CYCLES cycles with serve_req=0, then goes to IDLE.
  - serve_ack while serve_req=0 is ignored.
- Never more than one outstanding request. serve_req drops for at least 1 cycle between requests, even when HOLDOFF_CYCLES=0.

Optional Feature:
- Macro PED_ARB_STATS_EN.
- When defined: adds outputs served_cnt_ns [15:0] and served_cnt_ew [15:0]. Each increments on an accepted ack for its direction, saturates at 16'hFFFF, and resets to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- btn_ns pulses 1,0,1,0 every cycle for 8 cycles, then held high for 10 cycles → pending_ns rises exactly once, 6 cycles after the stable-high start; exactly one serve_req with serve_dir=0.
- btn_ew held high for 300 cycles, with serve_ack returned 5 cycles after each serve_req → exactly one request/ack; pending_ew=0 after the ack and stays 0 until release plus a re-press.
- btn_ns and btn_ew rise on the same edge after reset, with immediate acks → first serve_dir=0, second serve_dir=1 after the 8-cycle holdoff. Repeat the pair → order is NS then EW again (round-robin from last_served=EW).
- ack withheld from NS request; EW pressed and waits 64 cycles → urgent_ew=1 while serve_dir stays 0. After the NS ack and holdoff, the EW request issues; urgent_ew clears on its ack.
- rst asserted mid-REQ with both pending → all outputs 0 asynchronously; after release there is no serve_req until a new debounced press.
- with PED_ARB_STATS_EN defined, 3 NS acks and 1 EW ack → served_cnt_ns=3, served_cnt_ew=1.
